// File: rtl/swg_dyn_loop_controller.sv
// swg_dyn_loop_controller
// Walks a five-deep loop nest (h > w > kh > kw > simd, simd innermost) and
// reports, for each datapath advance, which signed address increment and
// which tail increment applies at the current position in the nest.
//
// Ports:
//   ap_clk, ap_rst         clock and synchronous active-high reset
//   cfg_valid / cfg_ready  configuration handshake (accepted only in IDLE)
//   cfg_loop_*             loop iteration counts minus one (unsigned)
//   cfg_incr_*             signed head increments
//   cfg_tail_*             unsigned tail increments
//   cfg_repeat             restart the same nest after every feature map
//   stop_req               leave repeat mode at the next feature-map end
//   advance                datapath consumed the current increment
//   addr_incr, tail_incr   increments for the current advance
//   busy                   high while walking a map (RUN)
//   fm_done                one-cycle pulse after the final advance of a map
module swg_dyn_loop_controller #(
    parameter int INCR_BITWIDTH = 9,
    parameter int CNT_BITWIDTH  = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CNT_BITWIDTH-1:0]  cfg_loop_h,
    input  logic [CNT_BITWIDTH-1:0]  cfg_loop_w,
    input  logic [CNT_BITWIDTH-1:0]  cfg_loop_kh,
    input  logic [CNT_BITWIDTH-1:0]  cfg_loop_kw,
    input  logic [CNT_BITWIDTH-1:0]  cfg_loop_simd,
    input  logic [INCR_BITWIDTH-1:0] cfg_incr_simd,
    input  logic [INCR_BITWIDTH-1:0] cfg_incr_kw,
    input  logic [INCR_BITWIDTH-1:0] cfg_incr_kh,
    input  logic [INCR_BITWIDTH-1:0] cfg_incr_w,
    input  logic [INCR_BITWIDTH-1:0] cfg_incr_h,
    input  logic [INCR_BITWIDTH-1:0] cfg_tail_w,
    input  logic [INCR_BITWIDTH-1:0] cfg_tail_h,
    input  logic [INCR_BITWIDTH-1:0] cfg_tail_last,
    input  logic                     cfg_repeat,
    input  logic                     stop_req,
    input  logic                     advance,
    output logic [INCR_BITWIDTH-1:0] addr_incr,
    output logic [INCR_BITWIDTH-1:0] tail_incr,
    output logic                     busy,
    output logic                     fm_done
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0, SEL_SIMD = 3'd1, SEL_KW = 3'd2,
        SEL_KH = 3'd3, SEL_W = 3'd4, SEL_H = 3'd5
    } sel_t;

    localparam logic [CNT_BITWIDTH-1:0]  CNT_ZERO  = {CNT_BITWIDTH{1'b0}};
    localparam logic [CNT_BITWIDTH-1:0]  CNT_ONE   = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [INCR_BITWIDTH-1:0] INCR_ZERO = {INCR_BITWIDTH{1'b0}};

    state_t                   state_r;
    logic                     fm_done_r;
    logic                     repeat_r;
    logic [CNT_BITWIDTH-1:0]  loop_h_r, loop_w_r, loop_kh_r, loop_kw_r, loop_simd_r;
    logic [CNT_BITWIDTH-1:0]  cnt_h_r, cnt_w_r, cnt_kh_r, cnt_kw_r, cnt_simd_r;
    logic [INCR_BITWIDTH-1:0] incr_simd_r, incr_kw_r, incr_kh_r, incr_w_r, incr_h_r;
    logic [INCR_BITWIDTH-1:0] tail_w_r, tail_h_r, tail_last_r;

    sel_t                     sel_s;
    logic                     cfg_ready_s;
    logic [INCR_BITWIDTH-1:0] addr_incr_s;
    logic [INCR_BITWIDTH-1:0] tail_incr_s;

    // Innermost non-zero counter decides which loop the next advance steps.
    always_comb begin
        sel_s = SEL_NONE;
        if (cnt_simd_r != CNT_ZERO) begin
            sel_s = SEL_SIMD;
        end else if (cnt_kw_r != CNT_ZERO) begin
            sel_s = SEL_KW;
        end else if (cnt_kh_r != CNT_ZERO) begin
            sel_s = SEL_KH;
        end else if (cnt_w_r != CNT_ZERO) begin
            sel_s = SEL_W;
        end else if (cnt_h_r != CNT_ZERO) begin
            sel_s = SEL_H;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Increment lookup; both increments are forced to zero outside RUN.
    always_comb begin
        addr_incr_s = INCR_ZERO;
        tail_incr_s = INCR_ZERO;
        if (state_r == ST_RUN) begin
            case (sel_s)
                SEL_SIMD: addr_incr_s = incr_simd_r;
                SEL_KW:   addr_incr_s = incr_kw_r;
                SEL_KH:   addr_incr_s = incr_kh_r;
                SEL_W:    addr_incr_s = incr_w_r;
                SEL_H:    addr_incr_s = incr_h_r;
                default:  addr_incr_s = INCR_ZERO;
            endcase
            // Tail selection looks only at the two outer counters.
            if (cnt_w_r != CNT_ZERO) begin
                tail_incr_s = tail_w_r;
            end else if (cnt_h_r != CNT_ZERO) begin
                tail_incr_s = tail_h_r;
            end else begin
                tail_incr_s = tail_last_r;
            end
        end else begin
            addr_incr_s = INCR_ZERO;
            tail_incr_s = INCR_ZERO;
        end
    end

    // Ready is suppressed during reset so no handshake can complete then.
    always_comb begin
        cfg_ready_s = (state_r == ST_IDLE) && !ap_rst;
    end

    // Controller state, latched configuration and loop counters.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r     <= ST_IDLE;
            fm_done_r   <= 1'b0;
            repeat_r    <= 1'b0;
            loop_h_r    <= CNT_ZERO;
            loop_w_r    <= CNT_ZERO;
            loop_kh_r   <= CNT_ZERO;
            loop_kw_r   <= CNT_ZERO;
            loop_simd_r <= CNT_ZERO;
            cnt_h_r     <= CNT_ZERO;
            cnt_w_r     <= CNT_ZERO;
            cnt_kh_r    <= CNT_ZERO;
            cnt_kw_r    <= CNT_ZERO;
            cnt_simd_r  <= CNT_ZERO;
            incr_simd_r <= INCR_ZERO;
            incr_kw_r   <= INCR_ZERO;
            incr_kh_r   <= INCR_ZERO;
            incr_w_r    <= INCR_ZERO;
            incr_h_r    <= INCR_ZERO;
            tail_w_r    <= INCR_ZERO;
            tail_h_r    <= INCR_ZERO;
            tail_last_r <= INCR_ZERO;
        end else begin
            fm_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // advance is deliberately ignored here, even on the
                    // handshake cycle: the first step happens in RUN.
                    if (cfg_valid && cfg_ready_s) begin
                        state_r     <= ST_RUN;
                        repeat_r    <= cfg_repeat;
                        loop_h_r    <= cfg_loop_h;
                        loop_w_r    <= cfg_loop_w;
                        loop_kh_r   <= cfg_loop_kh;
                        loop_kw_r   <= cfg_loop_kw;
                        loop_simd_r <= cfg_loop_simd;
                        cnt_h_r     <= cfg_loop_h;
                        cnt_w_r     <= cfg_loop_w;
                        cnt_kh_r    <= cfg_loop_kh;
                        cnt_kw_r    <= cfg_loop_kw;
                        cnt_simd_r  <= cfg_loop_simd;
                        incr_simd_r <= cfg_incr_simd;
                        incr_kw_r   <= cfg_incr_kw;
                        incr_kh_r   <= cfg_incr_kh;
                        incr_w_r    <= cfg_incr_w;
                        incr_h_r    <= cfg_incr_h;
                        tail_w_r    <= cfg_tail_w;
                        tail_h_r    <= cfg_tail_h;
                        tail_last_r <= cfg_tail_last;
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        case (sel_s)
                            SEL_SIMD: begin
                                cnt_simd_r <= cnt_simd_r - CNT_ONE;
                            end
                            SEL_KW: begin
                                cnt_kw_r   <= cnt_kw_r - CNT_ONE;
                                cnt_simd_r <= loop_simd_r;
                            end
                            SEL_KH: begin
                                cnt_kh_r   <= cnt_kh_r - CNT_ONE;
                                cnt_kw_r   <= loop_kw_r;
                                cnt_simd_r <= loop_simd_r;
                            end
                            SEL_W: begin
                                cnt_w_r    <= cnt_w_r - CNT_ONE;
                                cnt_kh_r   <= loop_kh_r;
                                cnt_kw_r   <= loop_kw_r;
                                cnt_simd_r <= loop_simd_r;
                            end
                            SEL_H: begin
                                cnt_h_r    <= cnt_h_r - CNT_ONE;
                                cnt_w_r    <= loop_w_r;
                                cnt_kh_r   <= loop_kh_r;
                                cnt_kw_r   <= loop_kw_r;
                                cnt_simd_r <= loop_simd_r;
                            end
                            default: begin
                                // Final advance of the map: all counters are zero.
                                fm_done_r <= 1'b1;
                                if (repeat_r && !stop_req) begin
                                    cnt_h_r    <= loop_h_r;
                                    cnt_w_r    <= loop_w_r;
                                    cnt_kh_r   <= loop_kh_r;
                                    cnt_kw_r   <= loop_kw_r;
                                    cnt_simd_r <= loop_simd_r;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_s;
    assign addr_incr = addr_incr_s;
    assign tail_incr = tail_incr_s;
    assign busy      = (state_r == ST_RUN);
    assign fm_done   = fm_done_r;

endmodule

// File: doc/swg_dyn_loop_controller.md
SWG_DYN_LOOP_CONTROLLER -- requirements
Module: swg_dyn_loop_controller

Interface
REQ-001 The block SHALL have parameter INCR_BITWIDTH, default 9: width of all signed increment fields and outputs.
REQ-002 The block SHALL have parameter CNT_BITWIDTH, default 16: width of all loop-count fields and counters.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have the following ports:
- ap_clk  in  1  clock; all state updates on its rising edge.
- ap_rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted when both valid and ready are high.
- cfg_loop_h, cfg_loop_w, cfg_loop_kh, cfg_loop_kw, cfg_loop_simd  in  CNT_BITWIDTH each  iterations minus 1, unsigned.
- cfg_incr_simd, cfg_incr_kw, cfg_incr_kh, cfg_incr_w, cfg_incr_h  in  INCR_BITWIDTH each  signed head increments.
- cfg_tail_w, cfg_tail_h, cfg_tail_last  in  INCR_BITWIDTH each  unsigned tail increments.
- cfg_repeat  in  1  restart the same loop nest automatically after each feature map.
- stop_req  in  1  level; leave repeat mode at the next feature-map end.
- advance  in  1  datapath consumed the current increment.
- addr_incr  out  INCR_BITWIDTH  signed head increment for the current advance.
- tail_incr  out  INCR_BITWIDTH  tail increment for the current advance.
- busy  out  1  high in state RUN.
- fm_done  out  1  one-cycle pulse marking the end of a feature map.

Function
REQ-005 The block SHALL have two states: IDLE and RUN.
REQ-006 cfg_ready SHALL equal (state==IDLE) and not ap_rst.
REQ-007 On a config handshake, the block SHALL latch all cfg_* fields.
REQ-008 On a config handshake, the block SHALL load counters h, w, kh, kw, simd from the cfg_loop_* fields.
REQ-009 On a config handshake, the state SHALL become RUN in the following cycle.
REQ-010 Loop nesting SHALL be h (outer) > w > kh > kw > simd (innermost).
REQ-011 In RUN, addr_incr SHALL be a combinational function of the registered counters, using this priority:
- simd!=0 -> incr_simd
- else kw!=0 -> incr_kw
- else kh!=0 -> incr_kh
- else w!=0 -> incr_w
- else h!=0 -> incr_h
- else 0
REQ-012 In RUN, tail_incr SHALL be tail_w if w!=0, else tail_h if h!=0, else tail_last.
REQ-013 In IDLE, addr_incr and tail_incr SHALL be 0.
REQ-014 On advance in RUN, the counter selected by REQ-011 SHALL decrement by 1.
REQ-015 On advance in RUN, all counters inner to the selected counter SHALL reload from the latched config.
REQ-016 The final advance SHALL be the one taken when all counters are 0.
REQ-017 On the final advance, fm_done SHALL be 1 in the next cycle only.
REQ-018 On the final advance with repeat=1 and stop_req=0, the block SHALL reload all counters in the same edge and stay in RUN with no bubble.
REQ-019 On the final advance with repeat=0 or stop_req=1, the block SHALL go to IDLE.
REQ-020 advance SHALL be ignored in IDLE, including an advance in the same cycle as the config handshake.
REQ-021 Counters SHALL be unsigned CNT_BITWIDTH; a cfg value of 0 means a single iteration.
REQ-022 addr_incr SHALL pass the signed latched value through unchanged; no arithmetic SHALL be applied to the increments.
REQ-023 Total advances per feature map SHALL equal the product of (cfg_loop_x+1) over all five loops.
REQ-024 When stop_req is asserted mid-map, the block SHALL complete the remaining advances of the map first.

Reset
REQ-025 While ap_rst=1, all outputs and counters SHALL be 0 and the state SHALL be IDLE.
REQ-026 While ap_rst=1, cfg_ready SHALL be 0.
REQ-027 Latched config SHALL be cleared to 0 on reset.
REQ-028 Reset asserted mid-RUN SHALL abort the map in the next cycle with no fm_done.
REQ-029 In the first cycle after reset release, cfg_ready SHALL be 1.

Verification
REQ-030 A bench SHALL cover: loops h=0, w=1, kh=0, kw=1, simd=1; incr simd=1, kw=1, w=-3; repeat=0; advance every cycle -> addr_incr sequence 1,1,1,-3,1,1,1,0; tail_incr = tail_w for advances 1-4 and tail_last for 5-8; fm_done one cycle after advance 8; then IDLE.
REQ-031 A bench SHALL cover: the REQ-030 config with repeat=1 and 20 advances -> fm_done after advances 8 and 16; the addr_incr sequence restarts at advance 9; busy stays 1.
REQ-032 A bench SHALL cover: repeat=1 with stop_req raised at advance 3 -> 8 advances complete, then fm_done, then IDLE with cfg_ready=1.
REQ-033 A bench SHALL cover: cfg_valid held during RUN -> cfg_ready=0 and no reload until one cycle after fm_done.
REQ-034 A bench SHALL cover: ap_rst pulsed after advance 5 -> busy=0, addr_incr=0 and no fm_done in the next cycle; a new config then starts a fresh 8-advance map.
REQ-035 A bench SHALL cover: all loops set to 0 -> a single advance with addr_incr=0 and tail_incr=tail_last, then fm_done.
